// File: rtl/mul32_seq.sv
// mul32_seq: iterative 32x32 -> 64 multiplier, one shift-add step per cycle.
// Ports: clk, rst (sync, active high), start/sgn/A/B request a multiply;
//        hi/lo hold the last 64-bit product, busy marks RUN/DONE,
//        done pulses for one cycle when hi/lo are updated.
// Config: define SIGNED_MUL_EN to enable the signed path (sgn=1);
//         without it sgn is ignored and every multiply is unsigned.
module mul32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mcand;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [4:0]  cnt;
    logic [32:0] sum;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] res;

`ifdef SIGNED_MUL_EN
    logic neg;
    logic neg_in;

    // Signed operands are reduced to magnitudes; 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag  = (sgn && A[31]) ? (~A + 32'd1) : A;
        b_mag  = (sgn && B[31]) ? (~B + 32'd1) : B;
        neg_in = sgn & (A[31] ^ B[31]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (state == IDLE && start) begin
            neg <= neg_in;
        end
    end

    assign res = neg ? (~{p_hi, p_lo} + 64'd1) : {p_hi, p_lo};
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign a_mag      = A;
    assign b_mag      = B;
    assign res        = {p_hi, p_lo};
`endif

    assign busy = (state != IDLE);

    // 33-bit add keeps the true carry-out, which becomes bit 63
    // after the right shift.
    assign sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : 33'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // hi/lo are written only when leaving DONE, so partial products
    // never show and an aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        p_hi  <= '0;
                        p_lo  <= b_mag;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    p_hi <= sum[32:1];
                    p_lo <= {sum[0], p_lo[31:1]};
                    cnt  <= cnt + 5'd1;
                end
                DONE: begin
                    hi   <= res[63:32];
                    lo   <= res[31:0];
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request a multiply; sampled only in IDLE.
REQ-004 sgn  input  1  1 = signed (two's-complement) operands, 0 = unsigned; sampled with start.
REQ-005 A  input  32  multiplicand; sampled with start.
REQ-006 B  input  32  multiplier; sampled with start.
REQ-007 hi  output  32  upper 32 bits of the 64-bit product.
REQ-008 lo  output  32  lower 32 bits of the 64-bit product.
REQ-009 busy  output  1  high in every cycle the block is in RUN or DONE.
REQ-010 done  output  1  single-cycle pulse marking hi/lo valid.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL latch A, B and sgn, clear the partial product, load the iteration counter with 0 and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-013 RUN SHALL last exactly 32 cycles, performing one shift-add iteration per cycle.
REQ-014 Each iteration SHALL work on the 65-bit vector {carry, P_hi, P_lo}:
  - If P_lo[0]=1, compute P_hi + multiplicand with a 32-bit add, carry-in 0 and true-high carry-out; otherwise add 0.
  - Shift the whole vector right by 1; the carry enters bit 63.
REQ-015 P_lo SHALL be initialised with the multiplier, so the product occupies {P_hi,P_lo} after 32 iterations.
REQ-016 After the 32nd iteration the block SHALL enter DONE; done=1 for exactly that one cycle, then the block returns to IDLE.
REQ-017 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+33, and hi/lo SHALL be valid in that cycle.
REQ-018 hi/lo SHALL hold the last result until the next accepted start; intermediate values SHALL NOT be visible on hi/lo during RUN.
REQ-019 start asserted in RUN or DONE SHALL be ignored and not queued; start in the cycle of return to IDLE SHALL be accepted normally.
REQ-020 Operand changes after the start cycle SHALL NOT affect the result.
REQ-021 Multiplying by 0 SHALL still take the full 32 RUN cycles; there is no early termination.

Reset
REQ-022 rst=1 SHALL force IDLE, hi=0, lo=0, busy=0, done=0 and clear all internal registers on the next edge.
REQ-023 rst during RUN or DONE SHALL abort the operation with no done pulse, and the discarded result SHALL NOT appear on hi/lo.
REQ-024 rst has priority over start in the same cycle.

Configuration
REQ-025 The macro SIGNED_MUL_EN SHALL compile the signed path in or out.
REQ-026 With SIGNED_MUL_EN defined and sgn=1:
  - Operands SHALL be converted to magnitudes at start.
  - The product sign SHALL be latched as A[31] XOR B[31].
  - The 64-bit result SHALL be two's-complement negated on entry to DONE when that sign is 1.
  - Latency SHALL be unchanged.
REQ-027 With SIGNED_MUL_EN undefined, sgn SHALL remain a port but be ignored, and all operations SHALL be unsigned.

Verification
REQ-028 A=3, B=5, sgn=0 -> done exactly 33 edges after start; hi=0x00000000, lo=0x0000000F.
REQ-029 A=B=0xFFFFFFFF, sgn=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SIGNED_MUL_EN defined: A=0xFFFFFFFE (-2), B=3, sgn=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; A=B=0xFFFFFFFF, sgn=1 -> hi=0, lo=1.
REQ-031 Start A=7, B=6; pulse start with A=2, B=2 in RUN cycle 10 -> single done pulse, lo=0x2A; no second operation follows.
REQ-032 Start A=9, B=9; rst in RUN cycle 20 -> busy=0 next cycle, no done pulse, hi=lo=0; a new start with A=4, B=4 then yields lo=0x10.
